wb_arbiter_2m: RTL
==================

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning slave-response watchdog limit in cycles (legal 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port wb_m0  wshb_if.slave  bundle  requester 0, highest priority after reset.
REQ-005 SHALL have port wb_m1  wshb_if.slave  bundle  requester 1.
REQ-006 SHALL have port wb_s  wshb_if.master  bundle  shared downstream slave, i.e. the BlockRAM.
REQ-007 SHALL use the bundle signals cyc, stb, we, adr[31:0], sel[3:0], dat_ms[31:0], dat_sm[31:0], ack, err and rty; bundle clk/rst are not used internally.

Function
REQ-008 SHALL implement FSM states IDLE, OWN0 and OWN1, plus a 1-bit round-robin pointer prio (0 = m0 favoured).
REQ-009 SHALL, in IDLE, go to OWN0 if only m0.cyc=1, OWN1 if only m1.cyc=1, or OWNprio if both are 1; otherwise stay in IDLE.
REQ-010 SHALL register the grant, giving one cycle of arbitration latency: a request seen in IDLE at edge N appears on wb_s from cycle N+1.
REQ-011 SHALL keep ownership while the owner holds cyc=1, including multiple stb cycles and wait states (bus lock).
REQ-012 SHALL, on the edge where the owner's cyc=0, return to IDLE and set prio to the non-owner; there is no direct OWN0->OWN1 transition.
REQ-013 SHALL, in OWNx, forward the owner's cyc, stb, we, adr, sel and dat_ms combinationally to wb_s.
REQ-014 SHALL, in IDLE, drive wb_s.cyc, wb_s.stb and wb_s.we to 0, and adr, sel and dat_ms to 0.
REQ-015 SHALL route wb_s.ack, err and rty only to the owner; the non-owner and IDLE see 0.
REQ-016 SHALL broadcast wb_s.dat_sm to both masters' dat_sm.
REQ-017 SHALL ignore a non-owner asserting cyc/stb: no ack is returned and its request is held pending.
REQ-018 SHALL drive wb_s.cyc=0 in the same cycle as an owner drops cyc mid-transfer; no response is delivered afterwards.

Reset
REQ-019 SHALL, while rst_n=0, set state=IDLE and prio=0, clear the watchdog counter, and force all outputs to 0.
REQ-020 SHALL act on reset asynchronously and release it synchronously to the next clk edge, with no grant in the release cycle.

Configuration
REQ-021 SHALL compile a watchdog under macro WB_ARB_TIMEOUT_EN.
REQ-022 SHALL, with WB_ARB_TIMEOUT_EN defined, use an 8-bit counter.
- Counter increments each cycle the owner has stb=1 and wb_s ack, err and rty are all 0.
- Counter clears on any response, on stb=0, or in IDLE.
- When the count reaches TIMEOUT_CYCLES-1, the owner gets a 1-cycle err=1, wb_s.stb is masked for that cycle, and the counter clears.
REQ-023 SHALL, without WB_ARB_TIMEOUT_EN, contain no counter; the owner then waits indefinitely for a slave response.

Structure
REQ-024 SHALL place the arb_state_t enum (IDLE, OWN0, OWN1) and ARB_TIMEOUT_DEFAULT=16 in package wb_arb_pkg.
REQ-025 SHALL isolate the watchdog in sub-module wb_arb_watchdog (inputs clk, rst_n, busy, resp; output expired), instantiated only under WB_ARB_TIMEOUT_EN.
REQ-026 SHALL keep the FSM, pointer and muxing in wb_arbiter_2m.

Verification
REQ-027 SHALL cover single master: m0 writes 0xDEADBEEF to adr 0x10 with sel=0xF, then reads it back -> m0 acks, read data 0xDEADBEEF, m1.ack stays 0 throughout.
REQ-028 SHALL cover simultaneous requests after reset: m0 and m1 raise cyc on the same edge -> m0 is granted first; after m0 drops cyc, m1 is granted 2 cycles later (IDLE cycle in between).
REQ-029 SHALL cover fairness: both masters hold cyc continuously for 4 transactions each -> grant order is 0,1,0,1,0,1,0,1.
REQ-030 SHALL cover bus lock: m1 does a 3-beat burst (adr 0x0, 0x4, 0x8) while m0 requests -> m0 gets no ack until m1 drops cyc.
REQ-031 SHALL cover reset mid-transfer: rst_n pulled low while OWN1 with stb=1 -> wb_s.cyc goes to 0 immediately (asynchronous), and after release m0 wins a simultaneous request.
REQ-032 SHALL cover timeout, with WB_ARB_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, using a stubbed slave that never acks -> m0.err pulses exactly 1 cycle, 4 cycles after stb rises.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

   localparam int unsigned WB_AW               = 32;
   localparam int unsigned WB_DW               = 32;
   localparam int unsigned WB_SW               = 4;
   localparam int unsigned ARB_TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   // Request-side payload of one master, as seen by the arbiter mux.
   typedef struct packed {
      logic             cyc;
      logic             stb;
      logic             we;
      logic [WB_AW-1:0] adr;
      logic [WB_SW-1:0] sel;
      logic [WB_DW-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic bundle connecting requesters, the arbiter and the shared slave.
interface wshb_if;
   import wb_arb_pkg::*;

   logic             cyc;
   logic             stb;
   logic             we;
   logic [WB_AW-1:0] adr;
   logic [WB_SW-1:0] sel;
   logic [WB_DW-1:0] dat_ms;
   logic [WB_DW-1:0] dat_sm;
   logic             ack;
   logic             err;
   logic             rty;

   modport master (output cyc, stb, we, adr, sel, dat_ms,
                   input  dat_sm, ack, err, rty);
   modport slave  (input  cyc, stb, we, adr, sel, dat_ms,
                   output dat_sm, ack, err, rty);
endinterface

// File: rtl/wb_arb_watchdog.sv
// Slave-response watchdog: flags a strobe left unanswered for TIMEOUT_CYCLES cycles.
module wb_arb_watchdog
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic busy,
   input  logic resp,
   output logic expired
);

   localparam int unsigned      CNT_W = 8;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Expiry ignores resp so a combinational slave cannot form a loop through the stb mask.
   assign expired = busy && (cnt_q == LIMIT);

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!busy || resp || expired) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with bus lock; optional response
// watchdog compiled in under WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m
   import wb_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
   input  logic   clk,
   input  logic   rst_n,
   wshb_if.slave  wb_m0,
   wshb_if.slave  wb_m1,
   wshb_if.master wb_s
);

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 2..255");
   end

   arb_state_t state_q, state_d;
   logic       prio_q, prio_d;
   logic       arb_en_q;
   wb_req_t    req0, req1, req_sel;
   logic       wd_expired;
   logic       m0_ack, m0_err, m0_rty;
   logic       m1_ack, m1_err, m1_rty;

   // arb_en_q holds off arbitration for the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         arb_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         arb_en_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      unique case (state_q)
         IDLE: begin
            if (arb_en_q) begin
               if (wb_m0.cyc && wb_m1.cyc) begin
                  state_d = prio_q ? OWN1 : OWN0;
               end else if (wb_m0.cyc) begin
                  state_d = OWN0;
               end else if (wb_m1.cyc) begin
                  state_d = OWN1;
               end
            end
         end
         OWN0: begin
            if (!wb_m0.cyc) begin
               state_d = IDLE;
               prio_d  = 1'b1;
            end
         end
         OWN1: begin
            if (!wb_m1.cyc) begin
               state_d = IDLE;
               prio_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign req0 = '{cyc: wb_m0.cyc, stb: wb_m0.stb, we: wb_m0.we,
                   adr: wb_m0.adr, sel: wb_m0.sel, dat: wb_m0.dat_ms};
   assign req1 = '{cyc: wb_m1.cyc, stb: wb_m1.stb, we: wb_m1.we,
                   adr: wb_m1.adr, sel: wb_m1.sel, dat: wb_m1.dat_ms};

   always_comb begin
      req_sel = '0;
      unique case (state_q)
         OWN0:    req_sel = req0;
         OWN1:    req_sel = req1;
         default: req_sel = '0;
      endcase
   end

   assign wb_s.cyc    = req_sel.cyc;
   assign wb_s.stb    = req_sel.stb & ~wd_expired;
   assign wb_s.we     = req_sel.we;
   assign wb_s.adr    = req_sel.adr;
   assign wb_s.sel    = req_sel.sel;
   assign wb_s.dat_ms = req_sel.dat;

`ifdef WB_ARB_TIMEOUT_EN
   wb_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .busy    ((state_q != IDLE) && req_sel.stb),
      .resp    (wb_s.ack | wb_s.err | wb_s.rty),
      .expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // Responses reach only the current owner; a watchdog expiry shows up as err.
   always_comb begin
      m0_ack = 1'b0;
      m0_err = 1'b0;
      m0_rty = 1'b0;
      m1_ack = 1'b0;
      m1_err = 1'b0;
      m1_rty = 1'b0;
      if (state_q == OWN0) begin
         m0_ack = wb_s.ack;
         m0_err = wb_s.err | wd_expired;
         m0_rty = wb_s.rty;
      end else if (state_q == OWN1) begin
         m1_ack = wb_s.ack;
         m1_err = wb_s.err | wd_expired;
         m1_rty = wb_s.rty;
      end
   end

   assign wb_m0.ack    = m0_ack;
   assign wb_m0.err    = m0_err;
   assign wb_m0.rty    = m0_rty;
   assign wb_m1.ack    = m1_ack;
   assign wb_m1.err    = m1_err;
   assign wb_m1.rty    = m1_rty;
   assign wb_m0.dat_sm = rst_n ? wb_s.dat_sm : '0;
   assign wb_m1.dat_sm = rst_n ? wb_s.dat_sm : '0;

endmodule
